// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings and the master FSM state type.
//   Contents:
//     htrans_t        HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//     HBURST_*        HBURST encodings used by the master (SINGLE, INCR4)
//     HSIZE_64        64-bit transfer size
//     HPROT_DATA      privileged, non-cacheable data access
//     mst_state_t     master FSM states
//     next_beat_addr  address increment between 64-bit beats
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HSIZE_64      = 3'b011;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } mst_state_t;

  localparam logic [31:0] BEAT_BYTES = 32'd8;

  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr);
    return addr + BEAT_BYTES;
  endfunction

endpackage

// File: rtl/ahb_master_wbuf.sv
// ---------------------------------------------------------------------------
// ahb_master_wbuf
//   4 x 64-bit write-data buffer feeding HWDATA. Contents are not reset.
//   Ports:
//     HCLK   in   clock
//     we     in   write enable (synchronous write)
//     widx   in   write entry index
//     wdata  in   write data
//     ridx   in   read entry index
//     rdata  out  read data (combinational)
// ---------------------------------------------------------------------------
module ahb_master_wbuf (
  input  logic        HCLK,
  input  logic        we,
  input  logic [1:0]  widx,
  input  logic [63:0] wdata,
  input  logic [1:0]  ridx,
  output logic [63:0] rdata
);

  logic [63:0] mem [4];

  always_ff @(posedge HCLK) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // A write to the entry currently being read shows up after the edge.
  assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//   Single-command AHB-Lite master issuing 64-bit SINGLE or INCR4 transfers
//   with pipelined address/data phases.
//   Optional feature macro: AHB_MASTER_LOCK_EN (adds cmd_lock, drives
//   HMASTLOCK for the whole command).
//   Ports:
//     HCLK, HRESET                      clock, async active-high reset
//     cmd_valid/cmd_ready               command handshake
//     cmd_write, cmd_burst4, cmd_addr   command fields (8-byte aligned addr)
//     cmd_lock                          locked command (macro only)
//     wbuf_we, wbuf_idx, wbuf_data      write-buffer load port
//     rd_valid, rd_idx, rd_data         read beat output
//     done, err                         completion pulse and error flag
//     HADDR..HWDATA                     AHB master outputs
//     HREADY, HRESP, HRDATA             AHB slave responses
// ---------------------------------------------------------------------------
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int BEATS_MAX = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_burst4,
  input  logic [31:0] cmd_addr,
`ifdef AHB_MASTER_LOCK_EN
  input  logic        cmd_lock,
`endif
  input  logic        wbuf_we,
  input  logic [1:0]  wbuf_idx,
  input  logic [63:0] wbuf_data,
  output logic        rd_valid,
  output logic [1:0]  rd_idx,
  output logic [63:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  mst_state_t  state_reg, state_next;
  htrans_t     htrans_reg, htrans_next;
  logic [31:0] haddr_reg, haddr_next;
  logic        hwrite_reg, hwrite_next;
  logic        burst4_reg, burst4_next;
  logic [1:0]  addr_beat_reg, addr_beat_next;   // beat in address phase
  logic [1:0]  data_beat_reg, data_beat_next;   // beat in data phase
  logic        rd_valid_reg, rd_valid_next;
  logic [1:0]  rd_idx_reg, rd_idx_next;
  logic [63:0] rd_data_reg, rd_data_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        ready_reg, ready_next;

  logic [63:0] wbuf_rdata;
  logic [1:0]  last_beat;
  logic        accept;
  logic        burst_ok;

  // Next address phase once the current one is accepted.
  htrans_t     step_htrans;
  logic [31:0] step_haddr;
  logic [1:0]  step_beat;

  ahb_master_wbuf u_wbuf (
    .HCLK  (HCLK),
    .we    (wbuf_we),
    .widx  (wbuf_idx),
    .wdata (wbuf_data),
    .ridx  (data_beat_reg),
    .rdata (wbuf_rdata)
  );

  assign accept    = cmd_valid && ready_reg;
  assign burst_ok  = (BEATS_MAX == 4) && cmd_burst4;
  assign last_beat = burst4_reg ? 2'd3 : 2'd0;

  always_comb begin
    step_htrans = HT_SEQ;
    step_haddr  = next_beat_addr(haddr_reg);
    step_beat   = addr_beat_reg + 2'd1;
    if (addr_beat_reg == last_beat) begin
      step_htrans = HT_IDLE;
      step_haddr  = haddr_reg;
      step_beat   = addr_beat_reg;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg     <= ST_IDLE;
      htrans_reg    <= HT_IDLE;
      haddr_reg     <= '0;
      hwrite_reg    <= 1'b0;
      burst4_reg    <= 1'b0;
      addr_beat_reg <= '0;
      data_beat_reg <= '0;
      rd_valid_reg  <= 1'b0;
      rd_idx_reg    <= '0;
      rd_data_reg   <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      htrans_reg    <= htrans_next;
      haddr_reg     <= haddr_next;
      hwrite_reg    <= hwrite_next;
      burst4_reg    <= burst4_next;
      addr_beat_reg <= addr_beat_next;
      data_beat_reg <= data_beat_next;
      rd_valid_reg  <= rd_valid_next;
      rd_idx_reg    <= rd_idx_next;
      rd_data_reg   <= rd_data_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      ready_reg     <= ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    htrans_next    = htrans_reg;
    haddr_next     = haddr_reg;
    hwrite_next    = hwrite_reg;
    burst4_next    = burst4_reg;
    addr_beat_next = addr_beat_reg;
    data_beat_next = data_beat_reg;
    rd_valid_next  = 1'b0;
    rd_idx_next    = rd_idx_reg;
    rd_data_next   = rd_data_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next     = ST_ADDR;
          htrans_next    = HT_NONSEQ;
          haddr_next     = cmd_addr;
          hwrite_next    = cmd_write;
          burst4_next    = burst_ok;
          addr_beat_next = 2'd0;
          data_beat_next = 2'd0;
        end
      end
      ST_ADDR: begin
        // First address phase: no data phase is outstanding yet.
        if (HREADY) begin
          state_next     = ST_DATA;
          data_beat_next = addr_beat_reg;
          htrans_next    = step_htrans;
          haddr_next     = step_haddr;
          addr_beat_next = step_beat;
        end
      end
      ST_DATA: begin
        if (HRESP) begin
          // Cancel any pending address phase on the first error cycle.
          htrans_next = HT_IDLE;
          if (HREADY) begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_ERR;
          end
        end else if (HREADY) begin
          if (!hwrite_reg) begin
            rd_valid_next = 1'b1;
            rd_idx_next   = data_beat_reg;
            rd_data_next  = HRDATA;
          end
          if (data_beat_reg == last_beat) begin
            done_next   = 1'b1;
            state_next  = ST_IDLE;
            htrans_next = HT_IDLE;
          end else begin
            // The overlapping address phase completes with this data phase.
            data_beat_next = addr_beat_reg;
            htrans_next    = step_htrans;
            haddr_next     = step_haddr;
            addr_beat_next = step_beat;
          end
        end
      end
      ST_ERR: begin
        htrans_next = HT_IDLE;
        if (HREADY) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Hold off acceptance during the done cycle.
    ready_next = (state_next == ST_IDLE) && !done_next;
  end

`ifdef AHB_MASTER_LOCK_EN
  logic lock_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      lock_reg <= 1'b0;
    end else if (accept) begin
      lock_reg <= cmd_lock;
    end
  end

  assign HMASTLOCK = lock_reg && (state_reg != ST_IDLE);
`else
  assign HMASTLOCK = 1'b0;
`endif

  assign cmd_ready = ready_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_idx    = rd_idx_reg;
  assign rd_data   = rd_data_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign HADDR     = haddr_reg;
  assign HTRANS    = htrans_reg;
  assign HWRITE    = hwrite_reg;
  assign HSIZE     = HSIZE_64;
  assign HBURST    = burst4_reg ? HBURST_INCR4 : HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HWDATA    = (hwrite_reg && (state_reg == ST_DATA || state_reg == ST_ERR))
                     ? wbuf_rdata : 64'd0;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_burst4;
  logic [31:0] cmd_addr;
`ifdef AHB_MASTER_LOCK_EN
  logic        cmd_lock;
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  logic        wbuf_we;
  logic [1:0]  wbuf_idx;
  logic [63:0] wbuf_data;
  logic        rd_valid;
  logic [1:0]  rd_idx;
  logic [63:0] rd_data;
  logic        done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY, HRESP;
  logic [63:0] HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.BEATS_MAX(4)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_burst4(cmd_burst4),
    .cmd_addr  (cmd_addr),
`ifdef AHB_MASTER_LOCK_EN
    .cmd_lock  (cmd_lock),
`endif
    .wbuf_we   (wbuf_we),
    .wbuf_idx  (wbuf_idx),
    .wbuf_data (wbuf_data),
    .rd_valid  (rd_valid),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic lock_exp = 1'b0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [63:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  bit      done_q[$];
  rd_exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ap(input string tag, input logic [1:0] tr, input logic [31:0] a);
    chk({tag, "_htrans"}, 64'(HTRANS), 64'(tr));
    if (tr != HT_IDLE) chk({tag, "_haddr"}, 64'(HADDR), 64'(a));
  endtask

  function automatic logic [63:0] wpat(input int i);
    return 64'hC0DE_5A5A_0000_0000 + 64'(i);
  endfunction

  task automatic wbuf_write(input int i, input logic [63:0] d);
    wbuf_we   = 1'b1;
    wbuf_idx  = 2'(i);
    wbuf_data = d;
    @(negedge HCLK);
    wbuf_we   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first address phase.
  task automatic issue(input logic wr, input logic b4, input logic [31:0] a, input logic lk);
    bit got;
    got        = 1'b0;
    cmd_write  = wr;
    cmd_burst4 = b4;
    cmd_addr   = a;
`ifdef AHB_MASTER_LOCK_EN
    cmd_lock   = lk;
`endif
    lock_exp   = LOCK_EN && lk;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      if (cmd_ready === 1'b1) got = 1'b1;
      @(negedge HCLK);
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(got), 64'd1);
  endtask

  // Scoreboard: every read beat and completion pops one expectation.
  always @(negedge HCLK) begin
    if (rd_valid === 1'b1) begin
      chk("rd_pending", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) begin
        mon_e = rd_q.pop_front();
        chk("rd_idx", 64'(rd_idx), 64'(mon_e.idx));
        chk("rd_data", rd_data, mon_e.data);
        $display("[TB] read beat idx=%0d data=0x%0h", rd_idx, rd_data);
      end
    end
    if (done === 1'b1) begin
      chk("done_pending", 64'(done_q.size() != 0), 64'd1);
      if (done_q.size() != 0) begin
        chk("done_err", 64'(err), 64'(done_q.pop_front()));
        $display("[TB] command done err=%0b", err);
      end
    end
  end

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst4 = 1'b0; cmd_addr = '0;
`ifdef AHB_MASTER_LOCK_EN
    cmd_lock = 1'b0;
`endif
    wbuf_we = 1'b0; wbuf_idx = '0; wbuf_data = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (2) @(negedge HCLK);

    // Reset values
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_haddr", 64'(HADDR), 64'd0);
    chk("rst_hwdata", HWDATA, 64'd0);
    chk("rst_hburst", 64'(HBURST), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_hlock", 64'(HMASTLOCK), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdvalid", 64'(rd_valid), 64'd0);
    chk("rst_rddata", rd_data, 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);
    wbuf_write(0, 64'hDEAD_BEEF_0000_0001);

    // SINGLE write to 0x1000 (lock requested)
    done_q.push_back(1'b0);
    issue(1'b1, 1'b0, 32'h0000_1000, 1'b1);
    chk_ap("t1_a", HT_NONSEQ, 32'h0000_1000);
    chk("t1_hwrite", 64'(HWRITE), 64'd1);
    chk("t1_hburst", 64'(HBURST), 64'(HBURST_SINGLE));
    chk("t1_hsize", 64'(HSIZE), 64'd3);
    chk("t1_hprot", 64'(HPROT), 64'd3);
    chk("t1_ready_busy", 64'(cmd_ready), 64'd0);
    chk("t1_lock_a", 64'(HMASTLOCK), 64'(lock_exp));
    @(negedge HCLK);
    chk_ap("t1_d", HT_IDLE, 32'h0);
    chk("t1_hwdata", HWDATA, 64'hDEAD_BEEF_0000_0001);
    chk("t1_lock_d", 64'(HMASTLOCK), 64'(lock_exp));
    chk("t1_done_early", 64'(done), 64'd0);
    @(negedge HCLK);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_ready_in_done", 64'(cmd_ready), 64'd0);
    chk("t1_lock_end", 64'(HMASTLOCK), 64'd0);
    @(negedge HCLK);
    chk("t1_ready_after", 64'(cmd_ready), 64'd1);
    $display("[TB] t1 single write 0x1000 complete");

    // INCR4 read from 0x2000, slave data 1..4
    for (int b = 0; b < 4; b++) rd_q.push_back('{idx: 2'(b), data: 64'(b + 1)});
    done_q.push_back(1'b0);
    issue(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    chk("t2_hburst", 64'(HBURST), 64'(HBURST_INCR4));
    for (int b = 0; b <= 4; b++) begin
      chk_ap($sformatf("t2_b%0d", b), (b == 0) ? HT_NONSEQ : ((b < 4) ? HT_SEQ : HT_IDLE),
             32'h0000_2000 + 32'(8 * b));
      HRDATA = 64'(b);
      @(negedge HCLK);
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_last_rd", 64'(rd_valid), 64'd1);
    chk("t2_lock", 64'(HMASTLOCK), 64'd0);
    HRDATA = '0;
    @(negedge HCLK);
    $display("[TB] t2 incr4 read 0x2000 complete");

    // INCR4 write to 0x3000 with a 3-cycle stall on beat 2
    for (int i = 0; i < 4; i++) wbuf_write(i, wpat(i));
    done_q.push_back(1'b0);
    issue(1'b1, 1'b1, 32'h0000_3000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      chk_ap($sformatf("t3_b%0d", b), (b == 0) ? HT_NONSEQ : HT_SEQ, 32'h0000_3000 + 32'(8 * b));
      if (b > 0) chk($sformatf("t3_hwdata%0d", b - 1), HWDATA, wpat(b - 1));
      if (b < 3) @(negedge HCLK);
    end
    HREADY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge HCLK);
      chk_ap($sformatf("t3_stall%0d", s), HT_SEQ, 32'h0000_3018);
      chk($sformatf("t3_stall%0d_hwdata", s), HWDATA, wpat(2));
      if (s == 2) HREADY = 1'b1;
    end
    @(negedge HCLK);
    chk_ap("t3_last", HT_IDLE, 32'h0);
    chk("t3_hwdata3", HWDATA, wpat(3));
    chk("t3_done_early", 64'(done), 64'd0);
    @(negedge HCLK);
    chk("t3_done", 64'(done), 64'd1);
    @(negedge HCLK);
    $display("[TB] t3 incr4 write 0x3000 with stall complete");

    // INCR4 read from 0x4000, slave errors on beat 1
    rd_q.push_back('{idx: 2'd0, data: 64'hA0A0});
    done_q.push_back(1'b1);
    issue(1'b0, 1'b1, 32'h0000_4000, 1'b0);
    chk_ap("t4_b0", HT_NONSEQ, 32'h0000_4000);
    @(negedge HCLK);
    chk_ap("t4_b1", HT_SEQ, 32'h0000_4008);
    HRDATA = 64'hA0A0;
    @(negedge HCLK);
    chk_ap("t4_b2", HT_SEQ, 32'h0000_4010);
    chk("t4_rd0", 64'(rd_valid), 64'd1);
    HREADY = 1'b0; HRESP = 1'b1; HRDATA = 64'hBAD;
    @(negedge HCLK);
    chk_ap("t4_err1", HT_IDLE, 32'h0);
    chk("t4_done_early", 64'(done), 64'd0);
    HREADY = 1'b1; HRESP = 1'b1;
    @(negedge HCLK);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_no_rd", 64'(rd_valid), 64'd0);
    HRESP = 1'b0;
    @(negedge HCLK);
    chk("t4_no_rd_after", 64'(rd_valid), 64'd0);
    chk("t4_htrans_after", 64'(HTRANS), 64'(HT_IDLE));
    @(negedge HCLK);
    chk("t4_ready", 64'(cmd_ready), 64'd1);
    $display("[TB] t4 incr4 read 0x4000 with error complete");

    // Reset pulse during beat 2 of an INCR4 read
    rd_q.push_back('{idx: 2'd0, data: 64'h55});
    issue(1'b0, 1'b1, 32'h0000_5000, 1'b0);
    chk_ap("t5_b0", HT_NONSEQ, 32'h0000_5000);
    @(negedge HCLK);
    chk_ap("t5_b1", HT_SEQ, 32'h0000_5008);
    HRDATA = 64'h55;
    @(negedge HCLK);
    chk_ap("t5_b2", HT_SEQ, 32'h0000_5010);
    HRDATA = 64'h66;
    #2 HRESET = 1'b1;
    #1;
    chk("t5_rst_htrans", 64'(HTRANS), 64'd0);
    chk("t5_rst_haddr", 64'(HADDR), 64'd0);
    chk("t5_rst_hburst", 64'(HBURST), 64'd0);
    chk("t5_rst_rddata", rd_data, 64'd0);
    chk("t5_rst_ready", 64'(cmd_ready), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    @(negedge HCLK);
    chk("t5_rst_held_htrans", 64'(HTRANS), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("t5_ready_after", 64'(cmd_ready), 64'd1);
    chk("t5_no_done", 64'(done), 64'd0);
    rd_q.push_back('{idx: 2'd0, data: 64'h77});
    done_q.push_back(1'b0);
    issue(1'b0, 1'b0, 32'h0000_6000, 1'b0);
    chk_ap("t5_new_a", HT_NONSEQ, 32'h0000_6000);
    chk("t5_new_hburst", 64'(HBURST), 64'(HBURST_SINGLE));
    @(negedge HCLK);
    chk_ap("t5_new_d", HT_IDLE, 32'h0);
    HRDATA = 64'h77;
    @(negedge HCLK);
    chk("t5_new_done", 64'(done), 64'd1);
    chk("t5_new_rd", 64'(rd_valid), 64'd1);
    @(negedge HCLK);
    $display("[TB] t5 reset mid-burst and new command complete");

    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    chk("done_queue_empty", 64'(done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter BEATS_MAX, default 4, the maximum burst length in beats; legal values are 1 and 4 only.
REQ-002 SHALL have port HCLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port HRESET, input, 1, the reset; asynchronous and active-high.
REQ-004 SHALL have these command ports:
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, command accepted when both cmd_valid and cmd_ready are high.
- cmd_write, input, 1, 1 for write, 0 for read.
- cmd_burst4, input, 1, 1 for INCR4, 0 for SINGLE.
- cmd_addr, input, 32, start address; must be 8-byte aligned.
REQ-005 SHALL have these write-buffer ports:
- wbuf_we, input, 1, write enable.
- wbuf_idx, input, 2, entry index.
- wbuf_data, input, 64, entry data; loaded before the command is issued.
REQ-006 SHALL have these read-data ports:
- rd_valid, output, 1, one-cycle pulse per read beat.
- rd_idx, output, 2, beat number.
- rd_data, output, 64, captured HRDATA.
REQ-007 SHALL have these completion ports:
- done, output, 1, one-cycle pulse at command end.
- err, output, 1, qualifies done; 1 means the slave returned an error.
REQ-008 SHALL have these AHB outputs: HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK, HWDATA[63:0].
REQ-009 SHALL have these AHB inputs: HREADY, HRESP, HRDATA[63:0].

Function
REQ-010 SHALL use FSM states IDLE, ADDR, DATA, ERR.
REQ-011 SHALL assert cmd_ready only in IDLE.
REQ-012 SHALL, on accept, latch the command and enter ADDR while driving HTRANS=NONSEQ with HADDR=cmd_addr.
REQ-013 SHALL hold HSIZE at 3'b011, HPROT at 4'b0011, and HBURST at SINGLE(000) or INCR4(011) per the latched command.
REQ-014 SHALL pipeline transfers: the address phase of beat n+1 overlaps the data phase of beat n; following beats use HTRANS=SEQ and HADDR incremented by 8; BUSY is never issued.
REQ-015 SHALL hold all address-phase and data-phase outputs stable while HREADY=0.
REQ-016 SHALL drive HWDATA with buffer entry n during the data phase of beat n (one cycle after its address phase is accepted).
REQ-017 SHALL, for reads, capture HRDATA when the data phase of beat n completes with HREADY=1 and HRESP=0, pulsing rd_valid with rd_idx=n.
REQ-018 SHALL drive HTRANS=IDLE once the final address phase is accepted, then pulse done with err=0 when the final data phase completes, returning to IDLE.
REQ-019 SHALL handle an error response (HRESP=1 with HREADY=0, the first error cycle) as follows:
- drive HTRANS=IDLE in the next cycle (cancelling any pending beat) and enter ERR;
- on the second error cycle (HRESP=1, HREADY=1), pulse done with err=1 and return to IDLE;
- issue no rd_valid for the errored beat or any later beat.
REQ-020 SHALL ignore cmd_valid while busy; a command presented in the same cycle as done is not accepted until the following cycle.
REQ-021 SHALL allow buffer writes at any time; a write landing on the entry being driven takes effect from the next cycle.
REQ-022 SHALL not cross 1 KB boundaries; this is caller-guaranteed and not checked.

Reset
REQ-023 SHALL, while HRESET=1, force:
- state IDLE;
- HTRANS=IDLE, HADDR=0, HWRITE=0, HBURST=0, HMASTLOCK=0, HWDATA=0;
- cmd_ready=0, rd_valid=0, done=0, err=0, rd_data=0.
REQ-024 SHALL abandon any in-flight transfer when reset asserts mid-burst, without emitting done; cmd_ready rises in the first cycle after release.
REQ-025 SHALL leave buffer contents unreset.

Configuration
REQ-026 SHALL, with AHB_MASTER_LOCK_EN defined, add input cmd_lock (1 bit) latched at accept; HMASTLOCK equals the latched value from the first address phase through the final data phase, then returns to 0.
REQ-027 SHALL, without AHB_MASTER_LOCK_EN, omit cmd_lock and tie HMASTLOCK to 0.

Structure
REQ-028 SHALL place in a shared package ahb_pkg:
- HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11);
- HBURST encodings (SINGLE, INCR4);
- HSIZE_64;
- the master FSM state enum.
REQ-029 SHALL implement the 4x64 write buffer as sub-module ahb_master_wbuf, with a synchronous write port and a combinational read port.

Verification
REQ-030 Write SINGLE to 0x0000_1000, entry0=0xDEAD_BEEF_0000_0001, HREADY=1 -> NONSEQ at 0x1000, HWDATA matches one cycle later, done=1 with err=0 two cycles after accept.
REQ-031 Read INCR4 from 0x2000 with slave data 1,2,3,4 -> HADDR 0x2000/0x2008/0x2010/0x2018 with NONSEQ,SEQ,SEQ,SEQ; rd_valid four times with rd_idx 0-3 and data 1-4; done on the last beat.
REQ-032 INCR4 write with HREADY=0 for 3 cycles on beat 2 -> HADDR, HTRANS and HWDATA stable throughout the stall; no beat lost.
REQ-033 Read INCR4 where the slave errors on beat 1 -> HTRANS=IDLE in the cycle after the first error cycle; exactly one rd_valid (idx 0); done=1 with err=1.
REQ-034 HRESET pulse during beat 2 of an INCR4 -> all outputs return to reset values, no done, and a new command is accepted after release.
REQ-035 With AHB_MASTER_LOCK_EN defined and cmd_lock=1 -> HMASTLOCK high from NONSEQ through the final data phase; without the macro, HMASTLOCK is always 0.
